// File: rtl/uart_rx.sv
// uart_rx: oversampled serial receiver for 8E1 frames
// (start 0, 8 data bits LSB first, even parity, stop 1).
// Optional build macro: UART_RX_MAJORITY_EN selects a 3-sample majority vote
// around the bit decision tick instead of a single sample.
//
// state  | meaning
// IDLE   | waiting for an armed low level on the synchronised line
// START  | qualifying the start bit at mid-bit (a 1 is a false start)
// DATA   | collecting 8 data bits, LSB first
// PARITY | capturing the even-parity bit
// STOP   | checking the stop bit, publishing the byte and flags
module uart_rx #(
  parameter int OSR = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx_tick,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int TW = $clog2(OSR);
  localparam logic [TW-1:0] MID  = TW'(OSR / 2);
  localparam logic [TW-1:0] LAST = TW'(OSR - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          armed_q, armed_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_done_q, rx_done_d;
  logic          parity_err_q, parity_err_d;
  logic          frame_err_q, frame_err_d;
  logic          rx_meta_q, rx_s_q;
  logic          bit_val;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  localparam logic [TW-1:0] VOTE_A = TW'(OSR / 2 - 2);
  localparam logic [TW-1:0] VOTE_B = TW'(OSR / 2 - 1);
  logic [1:0] vote_q;

  // Capture the two early votes; the third is the live sample at the decision tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vote_q <= 2'b11;
    end else if (rx_tick && state_q != S_IDLE) begin
      if (tick_cnt_q == VOTE_A) vote_q[1] <= rx_s_q;
      if (tick_cnt_q == VOTE_B) vote_q[0] <= rx_s_q;
    end
  end

  assign bit_val = (vote_q[1] & vote_q[0]) | (vote_q[1] & rx_s_q) | (vote_q[0] & rx_s_q);
`else
  assign bit_val = rx_s_q;
`endif

  // Next-state logic: everything advances only on rx_tick.
  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    armed_d      = armed_q;
    rx_data_d    = rx_data_q;
    rx_done_d    = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    if (rx_tick) begin
      if (state_q == S_IDLE) begin
        if (rx_s_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          // The detect tick itself counts as tick 0 of the start bit.
          state_d    = S_START;
          tick_cnt_d = TW'(1);
        end
      end else begin
        tick_cnt_d = (tick_cnt_q == LAST) ? '0 : tick_cnt_q + TW'(1);
        if (tick_cnt_q == MID) begin
          case (state_q)
            S_START: begin
              if (bit_val) begin
                state_d = S_IDLE;
              end else begin
                state_d   = S_DATA;
                bit_cnt_d = 3'd0;
              end
            end
            S_DATA: begin
              shift_d   = {bit_val, shift_q[7:1]};
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_d = S_PARITY;
            end
            S_PARITY: begin
              par_d   = bit_val;
              state_d = S_STOP;
            end
            S_STOP: begin
              // Leave at mid-stop so a back-to-back start edge is not missed.
              rx_data_d    = shift_q;
              parity_err_d = ^{shift_q, par_q};
              frame_err_d  = ~bit_val;
              rx_done_d    = 1'b1;
              if (!bit_val) armed_d = 1'b0;
              state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_q        <= 1'b0;
      armed_q      <= 1'b1;
      rx_data_q    <= 8'h00;
      rx_done_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      armed_q      <= armed_d;
      rx_data_q    <= rx_data_d;
      rx_done_q    <= rx_done_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_done    = rx_done_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign rx_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: behavioural frame source, reference model and scoreboard.
module tb_uart_rx;
  localparam int OSR  = 16;
  localparam int TDIV = 4;
  localparam int MIDT = OSR / 2;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_tick = 1'b0;
  logic       rx      = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;

  uart_rx #(.OSR(OSR)) dut (
    .clock(clock), .reset_n(reset_n), .rx_tick(rx_tick), .rx(rx),
    .rx_data(rx_data), .rx_done(rx_done), .parity_err(parity_err),
    .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #5 clock = ~clock;

  // Oversampling tick: one clock in every TDIV, driven away from the sampling edge.
  int tdiv = 0;
  always @(negedge clock) begin
    tdiv    = (tdiv + 1) % TDIV;
    rx_tick = (tdiv == 0);
  end

  int tcount = 0;
  always @(posedge clock) if (rx_tick) tcount++;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         tc;
  } exp_t;
  exp_t sbq[$];

  int total = 0, bad = 0;
  int npushed = 0, ndone = 0;
  logic busy_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every rx_done pops one expectation.
  always @(negedge clock) begin
    if (rx_busy) busy_seen = 1'b1;
    if (rx_done) begin
      ndone++;
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done actual=1 required=0 data=%0h", rx_data);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rx_data", {24'd0, rx_data}, {24'd0, e.d});
        chk("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
        chk("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
        chk("done_tick", tcount, e.tc);
      end
    end
  end

  // Behavioural view of how a bit is decided from the waveform ticks MIDT-2..MIDT.
  function automatic logic eff_bit(input logic b, input logic glitch);
    logic w6, w7, w8;
    w6 = b; w7 = b; w8 = b ^ glitch;
`ifdef UART_RX_MAJORITY_EN
    return (w6 & w7) | (w6 & w8) | (w7 & w8);
`else
    return w8;
`endif
  endfunction

  // Returns right after the next rx_tick edge; all line changes happen here.
  task automatic wait_tick();
    do @(posedge clock); while (!rx_tick);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) wait_tick();
  endtask

  task automatic hold_low(input int n);
    rx = 1'b0;
    repeat (n) wait_tick();
  endtask

  // Sends one frame; gbit >= 0 puts a one-tick inverted glitch at tick MIDT of that bit.
  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop,
                            input int gbit);
    logic [10:0] bits, e;
    exp_t x;
    bits = {stop, (^d) ^ pflip, d, 1'b0};
    for (int i = 0; i < 11; i++) e[i] = eff_bit(bits[i], (i == gbit));
    if (!e[0]) begin
      x.d  = e[8:1];
      x.pe = ^e[9:1];
      x.fe = ~e[10];
      x.tc = tcount + 1 + 8 + 10 * OSR;
      sbq.push_back(x);
      npushed++;
    end
    for (int i = 0; i < 11; i++)
      for (int j = 0; j < OSR; j++) begin
        rx = bits[i] ^ ((i == gbit) && (j == MIDT));
        wait_tick();
      end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 2000) begin
      @(posedge clock);
      n++;
    end
    chk("drain_timeout", sbq.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_done", {31'd0, rx_done}, 0);
    chk("rst_busy", {31'd0, rx_busy}, 0);
    chk("rst_data", {24'd0, rx_data}, 0);
    chk("rst_perr", {31'd0, parity_err}, 0);
    chk("rst_ferr", {31'd0, frame_err}, 0);
    reset_n = 1'b1;
    wait_tick();
    idle(20);

    send_frame(8'hA5, 1'b0, 1'b1, -1);
    idle(4);
    send_frame(8'h3C, 1'b1, 1'b1, -1);
    idle(4);

    // Break: stop bit low then line held low for three frame times.
    send_frame(8'h00, 1'b0, 1'b0, -1);
    hold_low(3 * 11 * OSR);
    drain();
    chk("break_busy", {31'd0, rx_busy}, 0);
    chk("break_ndone", ndone, npushed);
    idle(OSR);
    send_frame(8'h55, 1'b0, 1'b1, -1);
    idle(4);
    drain();

    // False start: 4 low ticks.
    busy_seen = 1'b0;
    hold_low(4);
    idle(20);
    chk("fstart_busy_seen", {31'd0, busy_seen}, 1);
    chk("fstart_busy_end", {31'd0, rx_busy}, 0);
    chk("fstart_ndone", ndone, npushed);

    // Glitch on data bit 3 (frame bit index 4) of 0x00.
    send_frame(8'h00, 1'b0, 1'b1, 4);
    idle(4);
    drain();

    // Reset in the middle of data bit 5.
    b = 8'($urandom_range(0, 255));
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < ((i == 6) ? MIDT : OSR); j++) begin
        rx = (i == 0) ? 1'b0 : b[i-1];
        wait_tick();
      end
    @(negedge clock);
    reset_n = 1'b0;
    rx = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, rx_busy}, 0);
    chk("midrst_data", {24'd0, rx_data}, 0);
    chk("midrst_done", {31'd0, rx_done}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    wait_tick();
    idle(2 * OSR);
    send_frame(8'h81, 1'b0, 1'b1, -1);
    idle(4);
    drain();

    // Random frames with random parity/stop corruption.
    for (int k = 0; k < 6; k++) begin
      send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), -1);
      idle(OSR);
    end

    // Back-to-back clean random bytes.
    for (int k = 0; k < 16; k++)
      send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1, -1);
    idle(20);
    drain();
    chk("final_ndone", ndone, npushed);
    chk("final_busy", {31'd0, rx_busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
